// File: rtl/sparse_mem_assoc_pkg.sv
// Shared types for the associative sparse memory: opcodes, FSM states, default widths.
package sparse_mem_assoc_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    MEM_READ  = 2'd0,
    MEM_WRITE = 2'd1,
    MEM_ERASE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } state_e;

endpackage

// File: rtl/sparse_mem_assoc_match.sv
// Combinational tag matcher: finds the resident slot for an address and the lowest free slot.
module sparse_mem_match #(
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]              addr,
  input  logic [ENTRIES-1:0][ADDR_WIDTH-1:0] tags,
  input  logic [ENTRIES-1:0]                 valids,
  output logic                               hit,
  output logic [$clog2(ENTRIES)-1:0]         hit_idx,
  output logic                               free_any,
  output logic [$clog2(ENTRIES)-1:0]         free_idx
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valids[i] && (tags[i] == addr) && !hit) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valids[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sparse_mem_assoc.sv
// Associative sparse memory with READ/WRITE/ERASE over valid/ready channels.
// Define SPARSE_MEM_EVICT_EN to evict round-robin on a write miss when full.
module sparse_mem_assoc
  import sparse_mem_assoc_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned             DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned             ENTRIES      = 16,
  parameter logic [DATA_WIDTH-1:0]   DEFAULT_DATA = '0
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  mem_op_e                        req_op,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_hit,
  output logic                           rsp_err,
  output logic [$clog2(ENTRIES+1)-1:0]   occupancy,
  output logic                           full
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned OCC_W = $clog2(ENTRIES+1);

  state_e                             state_q, state_d;
  logic                               ready_q, ready_d;
  mem_op_e                            op_q, op_d;
  logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
  logic [DATA_WIDTH-1:0]              wdata_q, wdata_d;
  logic                               rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]              rsp_data_q, rsp_data_d;
  logic                               rsp_hit_q, rsp_hit_d;
  logic                               rsp_err_q, rsp_err_d;
  logic [OCC_W-1:0]                   occ_q, occ_d;
  logic [ENTRIES-1:0]                 valid_q, valid_d;
  logic [ENTRIES-1:0][ADDR_WIDTH-1:0] slot_tag_q;
  logic [DATA_WIDTH-1:0]              slot_data_q [ENTRIES];
  logic                               wr_en;
  logic [IDX_W-1:0]                   wr_idx;
  logic                               hit, free_any;
  logic [IDX_W-1:0]                   hit_idx, free_idx;
`ifdef SPARSE_MEM_EVICT_EN
  logic [IDX_W-1:0]                   evict_ptr_q, evict_ptr_d;
`endif

  sparse_mem_match #(
    .ENTRIES    (ENTRIES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_match (
    .addr     (addr_q),
    .tags     (slot_tag_q),
    .valids   (valid_q),
    .hit      (hit),
    .hit_idx  (hit_idx),
    .free_any (free_any),
    .free_idx (free_idx)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_err_d   = rsp_err_q;
    occ_d       = occ_q;
    valid_d     = valid_q;
    wr_en       = 1'b0;
    wr_idx      = hit_idx;
`ifdef SPARSE_MEM_EVICT_EN
    evict_ptr_d = evict_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_data;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = '0;
        rsp_hit_d   = 1'b0;
        rsp_err_d   = 1'b0;
        case (op_q)
          MEM_READ: begin
            rsp_hit_d  = hit;
            rsp_data_d = hit ? slot_data_q[hit_idx] : DEFAULT_DATA;
          end
          MEM_WRITE: begin
            if (hit) begin
              rsp_hit_d = 1'b1;
              wr_en     = 1'b1;
            end else if (free_any) begin
              wr_en             = 1'b1;
              wr_idx            = free_idx;
              valid_d[free_idx] = 1'b1;
              occ_d             = occ_q + OCC_W'(1);
            end else begin
`ifdef SPARSE_MEM_EVICT_EN
              // Victim stays valid, so occupancy is untouched.
              wr_en       = 1'b1;
              wr_idx      = evict_ptr_q;
              evict_ptr_d = (evict_ptr_q == IDX_W'(ENTRIES-1)) ? '0 : evict_ptr_q + IDX_W'(1);
`else
              rsp_err_d = 1'b1;
`endif
            end
          end
          MEM_ERASE: begin
            if (hit) begin
              rsp_hit_d        = 1'b1;
              valid_d[hit_idx] = 1'b0;
              occ_d            = occ_q - OCC_W'(1);
            end
          end
          default: rsp_err_d = 1'b1;
        endcase
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      occ_q       <= '0;
      valid_q     <= '0;
`ifdef SPARSE_MEM_EVICT_EN
      evict_ptr_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_err_q   <= rsp_err_d;
      occ_q       <= occ_d;
      valid_q     <= valid_d;
`ifdef SPARSE_MEM_EVICT_EN
      evict_ptr_q <= evict_ptr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    if (wr_en) begin
      slot_tag_q[wr_idx]  <= addr_q;
      slot_data_q[wr_idx] <= wdata_q;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_err   = rsp_err_q;
  assign occupancy = occ_q;
  assign full      = (occ_q == OCC_W'(ENTRIES));

endmodule

// File: tb/tb_sparse_mem_assoc.sv
// Directed self-checking bench for sparse_mem_assoc (both SPARSE_MEM_EVICT_EN builds).
module tb_sparse_mem_assoc;
  import sparse_mem_assoc_pkg::*;

  localparam logic [31:0] DEF = 32'hBAD0_BEEF;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid;
  logic        req_ready;
  mem_op_e     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_hit;
  logic        rsp_err;
  logic [4:0]  occupancy;
  logic        full;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] r_data;
  logic        r_hit, r_err, r_full;
  logic [4:0]  r_occ;

  always #5 clk = ~clk;

  sparse_mem_assoc #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .ENTRIES      (16),
    .DEFAULT_DATA (DEF)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_hit   (rsp_hit),
    .rsp_err   (rsp_err),
    .occupancy (occupancy),
    .full      (full)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction; hold > 0 keeps rsp_ready low for that many cycles after rsp_valid.
  task automatic do_req(input mem_op_e op, input logic [31:0] a, input logic [31:0] d,
                        input int hold);
    int n;
    rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_data  = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = ~a;
    req_data  = ~d;
    n = 1;
    chk("rsp_early", {31'b0, rsp_valid}, 32'd0);
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, 32'd2);
    r_data = rsp_data;
    r_hit  = rsp_hit;
    r_err  = rsp_err;
    r_occ  = occupancy;
    r_full = full;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_data", rsp_data, r_data);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] data, input logic hit,
                            input logic err, input logic [4:0] occ);
    chk({tag, "_data"}, r_data, data);
    chk({tag, "_hit"}, {31'b0, r_hit}, {31'b0, hit});
    chk({tag, "_err"}, {31'b0, r_err}, {31'b0, err});
    chk({tag, "_occ"}, {27'b0, r_occ}, {27'b0, occ});
  endtask

  initial begin
    nrst      = 1'b0;
    req_valid = 1'b0;
    req_op    = MEM_READ;
    req_addr  = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_occ", {27'b0, occupancy}, 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_flags", {30'b0, rsp_hit, rsp_err}, 32'd0);
    nrst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    do_req(MEM_WRITE, 32'hDEAD_0000, 32'h0000_1234, 0);
    expect_rsp("wr_first", 32'h0, 1'b0, 1'b0, 5'd1);
    do_req(MEM_READ, 32'hDEAD_0000, 32'h0, 0);
    expect_rsp("rd_first", 32'h0000_1234, 1'b1, 1'b0, 5'd1);
    do_req(MEM_WRITE, 32'hDEAD_0000, 32'h0000_4321, 0);
    expect_rsp("wr_overwrite", 32'h0, 1'b1, 1'b0, 5'd1);
    do_req(MEM_READ, 32'hDEAD_0000, 32'h0, 0);
    expect_rsp("rd_overwrite", 32'h0000_4321, 1'b1, 1'b0, 5'd1);

    do_req(MEM_READ, 32'h0000_0040, 32'h0, 0);
    expect_rsp("rd_miss", DEF, 1'b0, 1'b0, 5'd1);

    for (int i = 0; i < 15; i++) begin
      do_req(MEM_WRITE, 32'h0000_1000 + 32'(i * 4), 32'h100 + 32'(i), 0);
      expect_rsp("fill", 32'h0, 1'b0, 1'b0, 5'(i + 2));
    end
    chk("full_set", {31'b0, r_full}, 32'd1);
    do_req(MEM_READ, 32'h0000_1020, 32'h0, 0);
    expect_rsp("rd_fill8", 32'h108, 1'b1, 1'b0, 5'd16);

    do_req(MEM_WRITE, 32'h0000_9999, 32'h0000_5555, 0);
`ifdef SPARSE_MEM_EVICT_EN
    expect_rsp("wr_evict", 32'h0, 1'b0, 1'b0, 5'd16);
    do_req(MEM_READ, 32'hDEAD_0000, 32'h0, 0);
    expect_rsp("rd_evicted", DEF, 1'b0, 1'b0, 5'd16);
    do_req(MEM_READ, 32'h0000_9999, 32'h0, 0);
    expect_rsp("rd_victor", 32'h0000_5555, 1'b1, 1'b0, 5'd16);
`else
    expect_rsp("wr_full", 32'h0, 1'b0, 1'b1, 5'd16);
    do_req(MEM_READ, 32'h0000_9999, 32'h0, 0);
    expect_rsp("rd_rejected", DEF, 1'b0, 1'b0, 5'd16);
    do_req(MEM_READ, 32'hDEAD_0000, 32'h0, 0);
    expect_rsp("rd_kept", 32'h0000_4321, 1'b1, 1'b0, 5'd16);
`endif

    do_req(MEM_ERASE, 32'h0000_1008, 32'h0, 0);
    expect_rsp("erase_hit", 32'h0, 1'b1, 1'b0, 5'd15);
    chk("full_clear", {31'b0, r_full}, 32'd0);
    do_req(MEM_ERASE, 32'h0000_1008, 32'h0, 0);
    expect_rsp("erase_miss", 32'h0, 1'b0, 1'b0, 5'd15);
    do_req(MEM_WRITE, 32'h0000_ABC0, 32'h0000_0077, 0);
    expect_rsp("wr_reuse", 32'h0, 1'b0, 1'b0, 5'd16);
    chk("full_again", {31'b0, r_full}, 32'd1);
    do_req(MEM_READ, 32'h0000_1008, 32'h0, 0);
    expect_rsp("rd_erased", DEF, 1'b0, 1'b0, 5'd16);
    do_req(mem_op_e'(2'b11), 32'h0000_ABC0, 32'h0, 0);
    expect_rsp("reserved_op", 32'h0, 1'b0, 1'b1, 5'd16);

    do_req(MEM_READ, 32'h0000_ABC0, 32'h0, 5);
    expect_rsp("rd_backpressure", 32'h0000_0077, 1'b1, 1'b0, 5'd16);

    // Reset lands while the request sits in LOOKUP; nothing may come back.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_op    = MEM_WRITE;
    req_addr  = 32'h0000_7000;
    req_data  = 32'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    nrst = 1'b0;
    #2;
    chk("midrst_occ", {27'b0, occupancy}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    chk("midrst_occ_after", {27'b0, occupancy}, 32'd0);
    chk("midrst_full_after", {31'b0, full}, 32'd0);
    do_req(MEM_READ, 32'h0000_ABC0, 32'h0, 0);
    expect_rsp("rd_after_rst", DEF, 1'b0, 1'b0, 5'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
